// File: rtl/conv_pkg.sv
// Shared types and constants for the sliding-window filter sequencer.
// Also holds the magnitude-to-pixel helper used on the result path.
package conv_pkg;

  localparam int MWSIZE_DEF = 7;
  localparam int WSIZE_MIN  = 3;
  localparam int ACC_W_DEF  = 32;

  typedef logic signed [ACC_W_DEF-1:0] acc_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_HOLD
  } state_e;

  // |a| clipped to 255; the most negative value negates to itself and still clips
  function automatic logic [7:0] abs_sat8(input acc_t a);
    logic [ACC_W_DEF-1:0] mag;
    mag = a[ACC_W_DEF-1] ? -a : a;
    if (mag > ACC_W_DEF'(255)) begin
      return 8'd255;
    end
    return mag[7:0];
  endfunction

endpackage

// File: rtl/conv_mac.sv
// Registered multiply-accumulate: unsigned 8-bit pixel times signed 16-bit
// coefficient, summed into a wrapping signed accumulator.
module conv_mac
  import conv_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic [7:0]              pix_i,
  input  logic signed [15:0]      coef_i,
  output logic signed [ACC_W-1:0] acc_o
);

  logic signed [8:0]       pix_s;
  logic signed [24:0]      prod;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;

  assign pix_s = {1'b0, pix_i};
  assign prod  = 25'(pix_s) * 25'(coef_i);

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/conv_window_seq.sv
// Window sequencer: walks every tap of a 3/5/7 window, feeds the MAC one tap
// per cycle, then holds the filtered result under a valid/ready handshake.
module conv_window_seq
  import conv_pkg::*;
#(
  parameter int MWSIZE  = MWSIZE_DEF,
  parameter int CADDR_W = 7,
  parameter int ACC_W   = ACC_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [$clog2(MWSIZE):0]    wsize,
  input  logic                       start,
  output logic                       busy,
  output logic                       cfg_err,
  output logic [CADDR_W-1:0]         coef_addr,
  input  logic [15:0]                coef_rdata,
  output logic [$clog2(MWSIZE)-1:0]  pix_row,
  output logic [$clog2(MWSIZE)-1:0]  pix_col,
  input  logic [7:0]                 pix_rdata,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [ACC_W-1:0]           res_acc,
  output logic [7:0]                 res_pix
);

  localparam int RC_W = $clog2(MWSIZE);
  localparam int WS_W = RC_W + 1;

  state_e            state_q, state_d;
  logic [WS_W-1:0]   ws_q, ws_d;
  logic [RC_W-1:0]   row_q, row_d;
  logic [RC_W-1:0]   col_q, col_d;
  logic              vld_q;
  logic              cfg_err_q, cfg_err_d;
  logic              mac_clr;
  logic              ws_legal;
  logic [WS_W-1:0]   ws_last;
  logic signed [ACC_W-1:0] acc;

  assign ws_legal = wsize[0] && (wsize >= WS_W'(WSIZE_MIN)) && (wsize <= WS_W'(MWSIZE));
  assign ws_last  = ws_q - WS_W'(1);

  always_comb begin
    state_d   = state_q;
    ws_d      = ws_q;
    row_d     = row_q;
    col_d     = col_q;
    cfg_err_d = 1'b0;
    mac_clr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (ws_legal) begin
            ws_d    = wsize;
            row_d   = '0;
            col_d   = '0;
            mac_clr = 1'b1;
            state_d = ST_RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        // the last tap's address is left in place for the rest of the run
        if ({1'b0, col_q} == ws_last) begin
          if ({1'b0, row_q} == ws_last) begin
            state_d = ST_DRAIN;
          end else begin
            col_d = '0;
            row_d = row_q + RC_W'(1);
          end
        end else begin
          col_d = col_q + RC_W'(1);
        end
      end
      ST_DRAIN: state_d = ST_HOLD;
      ST_HOLD: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ws_q      <= '0;
      row_q     <= '0;
      col_q     <= '0;
      vld_q     <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ws_q      <= ws_d;
      row_q     <= row_d;
      col_q     <= col_d;
      vld_q     <= (state_q == ST_RUN);
      cfg_err_q <= cfg_err_d;
    end
  end

  // RAM data returns one cycle after its address, so vld_q trails RUN by one
  conv_mac #(.ACC_W(ACC_W)) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (mac_clr),
    .en_i   (vld_q),
    .pix_i  (pix_rdata),
    .coef_i (coef_rdata),
    .acc_o  (acc)
  );

  assign busy      = (state_q != ST_IDLE);
  assign cfg_err   = cfg_err_q;
  assign coef_addr = CADDR_W'(row_q) * CADDR_W'(MWSIZE) + CADDR_W'(col_q);
  assign pix_row   = row_q;
  assign pix_col   = col_q;
  assign res_valid = (state_q == ST_HOLD);
  assign res_acc   = acc;
  assign res_pix   = abs_sat8(acc);

endmodule

// File: tb/tb_conv_window_seq.sv
// Bench for conv_window_seq: RAM models, a window-sum reference model with a
// per-cycle checker, and directed runs with hand-computed results.
module tb_conv_window_seq;

  logic        clk;
  logic        rst;
  logic [3:0]  wsize;
  logic        start;
  logic        busy;
  logic        cfg_err;
  logic [6:0]  coef_addr;
  logic [15:0] coef_rdata;
  logic [2:0]  pix_row;
  logic [2:0]  pix_col;
  logic [7:0]  pix_rdata;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_acc;
  logic [7:0]  res_pix;

  conv_window_seq dut (
    .clk        (clk),
    .rst        (rst),
    .wsize      (wsize),
    .start      (start),
    .busy       (busy),
    .cfg_err    (cfg_err),
    .coef_addr  (coef_addr),
    .coef_rdata (coef_rdata),
    .pix_row    (pix_row),
    .pix_col    (pix_col),
    .pix_rdata  (pix_rdata),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_acc    (res_acc),
    .res_pix    (res_pix)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic signed [15:0] coef_mem [0:127];
  logic [7:0]         pix_mem  [0:7][0:7];

  always @(posedge clk) begin
    coef_rdata <= coef_mem[coef_addr];
    pix_rdata  <= pix_mem[pix_row][pix_col];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat8(input int a);
    longint m;
    m = (a < 0) ? -longint'(a) : longint'(a);
    return (m > 255) ? 255 : int'(m);
  endfunction

  function automatic int window_sum(input int ws);
    longint s = 0;
    for (int r = 0; r < ws; r++)
      for (int c = 0; c < ws; c++)
        s += longint'(pix_mem[r][c]) * longint'(coef_mem[r*7 + c]);
    return int'(s);
  endfunction

  function automatic bit legal_ws(input int ws);
    return (ws % 2 == 1) && (ws >= 3) && (ws <= 7);
  endfunction

  // reference model state, advanced at each falling edge
  bit m_active    = 0;
  bit m_err_now   = 0;
  bit m_after_rst = 0;
  int m_cyc       = 0;
  int m_ws        = 3;
  int m_exp_acc   = 0;
  bit cap_seen    = 0;
  int cap_lat     = 0;
  int cap_acc     = 0;
  int cap_pix     = 0;
  int n_err_pulses = 0;

  always @(negedge clk) begin
    int n, k;
    n = m_ws * m_ws;
    chk("busy", busy, m_active);
    chk("cfg_err", cfg_err, m_err_now);
    chk("res_valid", res_valid, (m_active && m_cyc >= n + 2));
    if (m_active && m_cyc >= 1 && m_cyc <= n) begin
      k = m_cyc - 1;
      chk("pix_row", pix_row, k / m_ws);
      chk("pix_col", pix_col, k % m_ws);
      chk("coef_addr", coef_addr, (k / m_ws) * 7 + k % m_ws);
    end
    if (m_active && m_cyc >= n + 2) begin
      chk("res_acc", longint'($signed(res_acc)), m_exp_acc);
      chk("res_pix", res_pix, sat8(m_exp_acc));
      if (!cap_seen) begin
        cap_seen = 1;
        cap_lat  = m_cyc;
        cap_acc  = $signed(res_acc);
        cap_pix  = res_pix;
      end
    end
    if (m_after_rst) begin
      chk("rst_coef_addr", coef_addr, 0);
      chk("rst_pix_row", pix_row, 0);
      chk("rst_pix_col", pix_col, 0);
      chk("rst_res_acc", res_acc, 0);
      chk("rst_res_pix", res_pix, 0);
    end
    if (cfg_err) n_err_pulses++;

    if (rst) begin
      m_active    = 0;
      m_err_now   = 0;
      m_after_rst = 1;
    end else begin
      m_after_rst = 0;
      m_err_now   = 0;
      if (!m_active) begin
        if (start) begin
          if (legal_ws(int'(wsize))) begin
            m_active  = 1;
            m_cyc     = 1;
            m_ws      = int'(wsize);
            m_exp_acc = window_sum(int'(wsize));
          end else begin
            m_err_now = 1;
          end
        end
      end else if (m_cyc >= n + 2 && res_ready) begin
        m_active = 0;
      end else begin
        m_cyc++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 128; i++) coef_mem[i] = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) pix_mem[r][c] = '0;
  endtask

  task automatic load_sobel(input int left, input int mid, input int right);
    clear_mem();
    for (int r = 0; r < 3; r++) begin
      coef_mem[r*7 + 0] = (r == 1) ? -16'sd2 : -16'sd1;
      coef_mem[r*7 + 2] = (r == 1) ?  16'sd2 :  16'sd1;
      pix_mem[r][0] = 8'(left);
      pix_mem[r][1] = 8'(mid);
      pix_mem[r][2] = 8'(right);
    end
  endtask

  task automatic load_identity();
    clear_mem();
    coef_mem[8]   = 16'sd1;
    pix_mem[1][1] = 8'd200;
  endtask

  // bp: cycles res_ready stays low after the result appears; poke: cycle of a stray start
  task automatic run_win(input int ws, input int bp, input int poke);
    int t;
    cap_seen  = 0;
    res_ready = (bp == 0);
    wsize = 4'(ws);
    start = 1;
    tick();
    start = 0;
    t = 1;
    while (!cap_seen && t < 120) begin
      if (t == poke) begin
        start = 1;
        wsize = 4'd5;
      end
      tick();
      start = 0;
      t++;
    end
    chk("result_timeout", cap_seen, 1);
    repeat (bp) tick();
    res_ready = 1;
    t = 0;
    while (m_active && t < 10) begin
      tick();
      t++;
    end
    chk("handshake_timeout", m_active, 0);
  endtask

  initial begin
    int e0;
    int bad_ws [3] = '{4, 1, 9};
    rst = 1;
    start = 0;
    wsize = 4'd3;
    res_ready = 1;
    clear_mem();
    repeat (3) tick();
    rst = 0;
    chk("reset_busy", busy, 0);
    chk("reset_res_valid", res_valid, 0);
    chk("reset_cfg_err", cfg_err, 0);
    chk("reset_coef_addr", coef_addr, 0);
    chk("reset_res_acc", res_acc, 0);
    chk("reset_res_pix", res_pix, 0);
    tick();

    load_identity();
    run_win(3, 0, 0);
    chk("identity_acc", cap_acc, 200);
    chk("identity_pix", cap_pix, 200);
    chk("identity_latency", cap_lat, 11);

    load_sobel(0, 100, 255);
    run_win(3, 0, 0);
    chk("sobel_acc", cap_acc, 1020);
    chk("sobel_pix", cap_pix, 255);

    load_sobel(255, 100, 0);
    run_win(3, 0, 0);
    chk("sobel_neg_acc", cap_acc, -1020);
    chk("sobel_neg_pix", cap_pix, 255);

    load_sobel(77, 77, 77);
    run_win(3, 0, 0);
    chk("uniform_acc", cap_acc, 0);
    chk("uniform_pix", cap_pix, 0);

    clear_mem();
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++) begin
        coef_mem[r*7 + c] = 16'sd1;
        pix_mem[r][c] = 8'd1;
      end
    run_win(7, 0, 0);
    chk("ones7_acc", cap_acc, 49);
    chk("ones7_latency", cap_lat, 51);

    clear_mem();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        coef_mem[r*7 + c] = 16'(r - c);
        pix_mem[r][c] = 8'(10 * r + c);
      end
    run_win(5, 0, 0);
    chk("ramp5_latency", cap_lat, 27);

    load_identity();
    run_win(3, 10, 0);
    chk("backpressure_acc", cap_acc, 200);

    load_sobel(0, 100, 255);
    run_win(3, 0, 4);
    chk("stray_start_acc", cap_acc, 1020);
    chk("stray_start_latency", cap_lat, 11);

    foreach (bad_ws[i]) begin
      e0 = n_err_pulses;
      wsize = 4'(bad_ws[i]);
      start = 1;
      tick();
      start = 0;
      repeat (3) tick();
      chk("cfg_err_pulses", n_err_pulses - e0, 1);
      chk("cfg_err_busy", busy, 0);
    end

    cap_seen = 0;
    wsize = 4'd5;
    start = 1;
    tick();
    start = 0;
    repeat (4) tick();
    rst = 1;
    tick();
    rst = 0;
    chk("midrun_rst_busy", busy, 0);
    repeat (40) tick();
    chk("midrun_rst_no_result", cap_seen, 0);

    load_identity();
    run_win(3, 0, 0);
    chk("after_rst_acc", cap_acc, 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
